// File: rtl/prio_pkg.sv
// Shared constants for the priority encoder/arbiter slice.
// MODE selects between fixed highest-index priority and round-robin.
package prio_pkg;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

endpackage : prio_pkg

// File: rtl/prio_pick.sv
// Combinational picker: first set bit of vec, searching downward from start
// and wrapping from index 0 back to N-1.
module prio_pick #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         any
);

    int j;

    // NOTE: every output and temporary gets a default at the top of always_comb,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        idx = '0;
        any = 1'b0;
        j   = 0;
        // Walk from the farthest candidate to start; the last hit wins,
        // which makes start the highest-priority position.
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(start) - k;
            if (j < 0) j = j + N;
            if (vec[W'(j)]) begin
                idx = W'(j);
                any = 1'b1;
            end
        end
    end

endmodule : prio_pick

// File: rtl/prio_encoder_arb.sv
// Registered priority encoder / arbiter with pending-request latch and
// valid/ack output handshake; fixed or round-robin selection via MODE.
module prio_encoder_arb
    import prio_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int MODE = PRIO_FIXED,
    localparam int W    = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] i,
    input  logic         ack,
    output logic [W-1:0] y,
    output logic         valid,
    output logic [N-1:0] pend
);

    logic [W-1:0] ptr;
    logic [W-1:0] start;
    logic [W-1:0] pick_idx;
    logic         pick_any;
    logic         load;
    logic         grant;
    logic [N-1:0] clr;
    logic [N-1:0] pend_next;

    // After reset ptr=0, so the first round-robin search starts at N-1.
    assign start = (MODE == PRIO_RR) ? ((ptr == '0) ? W'(N - 1) : ptr - W'(1))
                                     : W'(N - 1);

    prio_pick #(.N(N)) u_pick (
        .vec   (pend),
        .start (start),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign load  = en && (!valid || ack);
    assign grant = load && pick_any;
    assign clr   = grant ? ({{(N-1){1'b0}}, 1'b1} << pick_idx) : '0;

    // New requests are OR-ed in after the clear, so a same-edge re-request survives.
    assign pend_next = (pend & ~clr) | (en ? i : '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= '0;
            ptr   <= '0;
            y     <= '0;
            valid <= 1'b0;
        end else begin
            pend <= pend_next;
            if (load) begin
                valid <= pick_any;
            end
            if (grant) begin
                y   <= pick_idx;
                ptr <= pick_idx;
            end
        end
    end

endmodule : prio_encoder_arb
